// File: rtl/ps2_keys_ctl_if.sv
// PS/2 key controller bus: raw keyboard pins in, decoded key levels and
// debug byte stream out. The slave side is the controller, the master side
// is whatever drives the pins and consumes the key levels.
interface ps2_keys_ctl_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  key_space,
    input  key_left,
    input  key_right,
    input  rx_byte,
    input  rx_valid,
    input  rx_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key_space,
    output key_left,
    output key_right,
    output rx_byte,
    output rx_valid,
    output rx_err
  );
endinterface

// File: rtl/ps2_keys_ctl.sv
// PS/2 keyboard receiver and scan-code set 2 decoder.
// Raw pins are synchronized, the PS/2 clock is glitch filtered, frames are
// assembled on falling filtered-clock edges and make/break sequences are
// turned into held-key levels for space, left and right.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | waiting for a start bit (data=0 on a clock fall)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the odd-parity bit
// RX_STOP   | checking stop bit and parity, emitting byte or error
module ps2_keys_ctl #(
  parameter int         FILTER_LEN  = 8,
  parameter int         TIMEOUT_CYC = 65_000,
  parameter logic [7:0] SC_SPACE    = 8'h29,
  parameter logic [7:0] SC_LEFT     = 8'h6B,
  parameter logic [7:0] SC_RIGHT    = 8'h74
) (
  input  logic           clk,
  input  logic           rst,
  ps2_keys_ctl_if.slave  bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FW-1:0] F_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic          filt_q;
  logic [FW-1:0] fcnt;
  logic          bit_ev;
  logic          bit_dat;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic [7:0]    rx_byte_q;
  logic          rx_valid_q;
  logic          rx_err_q;

  logic          brk;
  logic          ext;
  logic          key_space_q;
  logic          key_left_q;
  logic          key_right_q;

  // Two-flop synchronizers; both pins idle high so reset them to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
    end
  end

  // Clock filter: follow the synced clock only after FILTER_LEN samples in a row disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_q <= filt;
      if (clk_sync[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == F_LAST) begin
        filt <= clk_sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // A bit is presented on every falling edge of the filtered clock.
  assign bit_ev  = filt_q & ~filt;
  assign bit_dat = data_sync[1];

  // Frame receiver with mid-frame inactivity timeout; strobes are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;

      if (state == RX_IDLE || bit_ev) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      // A bit event in the same cycle as the terminal count wins: it restarts the timer.
      if (state != RX_IDLE && !bit_ev && to_cnt == TO_LAST) begin
        state    <= RX_IDLE;
        rx_err_q <= 1'b1;
      end else if (bit_ev) begin
        case (state)
          RX_IDLE: begin
            if (!bit_dat) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            sr <= {bit_dat, sr[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= RX_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          RX_PARITY: begin
            par   <= bit_dat;
            state <= RX_STOP;
          end
          RX_STOP: begin
            if ((^{sr, par}) && bit_dat) begin
              rx_byte_q  <= sr;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  // Make/break decoder: prefixes set flags, any other byte is a code that consumes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      key_space_q <= 1'b0;
      key_left_q  <= 1'b0;
      key_right_q <= 1'b0;
    end else if (rx_valid_q) begin
      case (rx_byte_q)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        default: begin
          if (rx_byte_q == SC_SPACE) key_space_q <= !brk;
          if (rx_byte_q == SC_LEFT)  key_left_q  <= !brk;
          if (rx_byte_q == SC_RIGHT) key_right_q <= !brk;
          brk <= 1'b0;
          ext <= 1'b0;
        end
      endcase
    end
  end

  // The extended prefix is tracked but arrow and keypad codes are treated alike.
  logic unused_ext;
  assign unused_ext = ext;

  assign bus.rx_byte   = rx_byte_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_err    = rx_err_q;
  assign bus.key_space = key_space_q;
  assign bus.key_left  = key_left_q;
  assign bus.key_right = key_right_q;

endmodule

// File: tb/tb_ps2_keys_ctl.sv
// Directed bench for ps2_keys_ctl: frames are pushed to a scoreboard as they
// are sent and matched against rx_valid/rx_err strobes; key levels are
// checked after each frame.
module tb_ps2_keys_ctl;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int HALF        = 50;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_strobes = 0;
  int   cyc = 0;
  int   stop_fall_cyc = 0;
  int   valid_cyc = 0;
  logic ks_at_v = 1'b0;
  logic ks_after_v = 1'b0;
  logic v_pend = 1'b0;
  exp_t exp_q[$];

  ps2_keys_ctl_if bus ();

  ps2_keys_ctl #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SC_SPACE   (8'h29),
    .SC_LEFT    (8'h6B),
    .SC_RIGHT   (8'h74)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && (bus.rx_valid || bus.rx_err)) begin
      exp_t e;
      logic [9:0] obs, expv;
      n_strobes++;
      n_checks++;
      assert (exp_q.size() != 0)
      else begin
        n_errors++;
        $error("FAIL unexpected_strobe: observed valid=%0b err=%0b byte=%02h, expected none",
               bus.rx_valid, bus.rx_err, bus.rx_byte);
      end
      if (exp_q.size() != 0) begin
        e    = exp_q.pop_front();
        obs  = {bus.rx_err, bus.rx_valid, bus.rx_valid ? bus.rx_byte : 8'h00};
        expv = {e.err, ~e.err, e.err ? 8'h00 : e.b};
        n_checks++;
        assert (obs === expv)
        else begin
          n_errors++;
          $error("FAIL rx_strobe: observed %03h, expected %03h", obs, expv);
        end
      end
    end
  end

  // Key level at the rx_valid cycle and the cycle after, for the latency check.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_cyc = cyc;
      ks_at_v   = bus.key_space;
      v_pend    = 1'b1;
    end else if (v_pend) begin
      ks_after_v = bus.key_space;
      v_pend     = 1'b0;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic p;
    p = ~(^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      repeat (HALF / 2) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    exp_q.push_back('{err: 1'b0, b: b});
    send_bits(mk_frame(b, 1'b0), 11);
  endtask

  task automatic send_bad(input logic [7:0] b);
    exp_q.push_back('{err: 1'b1, b: 8'h00});
    send_bits(mk_frame(b, 1'b1), 11);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_keys(input string tag, input logic [2:0] expv);
    check(tag, {29'd0, bus.key_space, bus.key_left, bus.key_right}, {29'd0, expv});
  endtask

  initial begin
    int s0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs",
          {19'd0, bus.key_space, bus.key_left, bus.key_right, bus.rx_byte, bus.rx_valid, bus.rx_err},
          32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: make 29, latency, then break
    send(8'h29);
    check("valid_latency_range",
          {31'd0, (valid_cyc - stop_fall_cyc >= FILTER_LEN + 2) &&
                  (valid_cyc - stop_fall_cyc <= FILTER_LEN + 4)}, 32'd1);
    check("space_at_valid", {31'd0, ks_at_v}, 32'd0);
    check("space_after_valid", {31'd0, ks_after_v}, 32'd1);
    check_keys("make_space", 3'b100);
    send(8'hF0);
    send(8'h29);
    check_keys("break_space", 3'b000);

    // 2: extended arrows, both held, then release
    send(8'hE0); send(8'h6B);
    check_keys("make_left", 3'b010);
    send(8'hE0); send(8'h74);
    check_keys("make_right", 3'b011);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_keys("break_left", 3'b001);
    send(8'hE0); send(8'hF0); send(8'h74);
    check_keys("break_right", 3'b000);

    // 3: bad parity is dropped, good frame follows
    send_bad(8'h74);
    check_keys("bad_parity_no_key", 3'b000);
    send(8'h74);
    check_keys("right_after_bad", 3'b001);

    // 4: truncated frame times out
    exp_q.push_back('{err: 1'b1, b: 8'h00});
    send_bits(mk_frame(8'h29, 1'b0), 5);
    repeat (TIMEOUT_CYC + 100) @(negedge clk);
    check("timeout_err_seen", exp_q.size(), 32'd0);
    check_keys("keys_after_timeout", 3'b001);
    send(8'h29);
    check_keys("space_after_timeout", 3'b101);

    // 5: short clock glitch with data low in idle
    s0 = n_strobes;
    bus.ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (15) @(negedge clk);
    bus.ps2_data = 1'b1;
    repeat (TIMEOUT_CYC + 100) @(negedge clk);
    check("glitch_no_strobe", n_strobes - s0, 32'd0);
    send(8'hAA);
    check_keys("keys_after_glitch", 3'b101);

    // 6: typematic repeat, break of unheld key, reset mid-frame
    for (int i = 0; i < 3; i++) begin
      send(8'h29);
      check_keys("typematic_space", 3'b101);
    end
    send(8'hF0); send(8'h6B);
    check_keys("break_unheld_left", 3'b101);
    send_bits(mk_frame(8'h6B, 1'b0), 4);
    rst = 1'b1;
    @(negedge clk);
    check("reset_midframe_outputs",
          {19'd0, bus.key_space, bus.key_left, bus.key_right, bus.rx_byte, bus.rx_valid, bus.rx_err},
          32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    send(8'h6B);
    check_keys("keypad_left_after_reset", 3'b010);

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
